// File: rtl/speed_event_ctrl.sv
// speed_event_ctrl: converts raw up/down/reset speed buttons into clean
// single-cycle speed_*_event pulses for clock_divider. Each button is
// synchronised, debounced and edge-detected, and the result is latched as a
// pending request. A small FSM issues one request at a time, in the priority
// order reset > up > down. After each issued event it waits out a hold-off
// window. It tracks speed_level and drops up/down requests beyond the limits.
//
// Optional feature: define SPEED_AUTO_REPEAT_EN to re-arm the up/down
// requests every REPEAT_CYCLES while the debounced button stays pressed.
module speed_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int HOLDOFF_CYCLES  = 1000,
  parameter int LEVEL_W         = 4,
  parameter int LEVEL_MAX       = 15,
  parameter int LEVEL_MIN       = 0,
  parameter int LEVEL_DEFAULT   = 8
`ifdef SPEED_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 13500000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_reset,
  output logic               speed_up_event,
  output logic               speed_down_event,
  output logic               speed_reset_event,
  output logic [LEVEL_W-1:0] speed_level,
  output logic               busy
);

  // Button index order; it also drives the priority order in IDLE.
  localparam int B_RST = 0;
  localparam int B_UP  = 1;
  localparam int B_DN  = 2;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      smp_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [2:0]      db_q, db_prev_q;
  logic [2:0]      rise;
  logic [2:0]      rpt_hit;
  logic [2:0]      req_set;

  state_t          state_q;
  logic [2:0]      sel_q;
  logic [2:0]      pend_q;
  logic [2:0]      pick;
  logic [2:0]      pend_clr;
  logic [HO_W-1:0] ho_cnt_q;
  logic [LEVEL_W-1:0] level_q;
  logic            up_evt_q, dn_evt_q, rst_evt_q, busy_q;
  logic            at_max, at_min;

  assign btn_raw = {btn_down, btn_up, btn_reset};

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a level only after it has stayed unchanged long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      smp_q     <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
    end else begin
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != smp_q[i]) begin
          smp_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_q[i] <= smp_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Only press edges of the debounced level become requests.
  assign rise = db_q & ~db_prev_q;

`ifdef SPEED_AUTO_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rpt_cnt_q [1:2];

  // Auto-repeat period timer per up/down button, restarted by each press edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 2; i++) rpt_cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i <= 2; i++) begin
        if (!db_q[i] || rise[i] || rpt_cnt_q[i] == RP_LAST) begin
          rpt_cnt_q[i] <= '0;
        end else begin
          rpt_cnt_q[i] <= rpt_cnt_q[i] + RP_W'(1);
        end
      end
    end
  end

  // A full period with the button still held re-arms its request.
  always_comb begin
    rpt_hit = '0;
    for (int i = 1; i <= 2; i++) begin
      rpt_hit[i] = db_q[i] && !rise[i] && (rpt_cnt_q[i] == RP_LAST);
    end
  end
`else
  assign rpt_hit = '0;
`endif

  assign req_set = rise | rpt_hit;
  assign at_max  = (level_q == LEVEL_W'(LEVEL_MAX));
  assign at_min  = (level_q == LEVEL_W'(LEVEL_MIN));

  // Request selection in IDLE (with saturation drops) and pending-bit clears.
  always_comb begin
    pick     = '0;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        if (pend_q[B_RST]) begin
          pick[B_RST] = 1'b1;
        end else if (pend_q[B_UP]) begin
          if (at_max) pend_clr[B_UP] = 1'b1;
          else        pick[B_UP]     = 1'b1;
        end else if (pend_q[B_DN]) begin
          if (at_min) pend_clr[B_DN] = 1'b1;
          else        pick[B_DN]     = 1'b1;
        end
      end
      ISSUE:   pend_clr = sel_q;
      default: ;
    endcase
  end

  // Issue FSM with registered event pulses, busy flag and speed level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pend_q    <= '0;
      ho_cnt_q  <= '0;
      level_q   <= LEVEL_W'(LEVEL_DEFAULT);
      up_evt_q  <= 1'b0;
      dn_evt_q  <= 1'b0;
      rst_evt_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // A fresh press landing in the clearing cycle is kept, not lost.
      pend_q <= (pend_q & ~pend_clr) | req_set;
      case (state_q)
        IDLE: begin
          if (pick != '0) begin
            state_q   <= ISSUE;
            sel_q     <= pick;
            busy_q    <= 1'b1;
            rst_evt_q <= pick[B_RST];
            up_evt_q  <= pick[B_UP];
            dn_evt_q  <= pick[B_DN];
          end
        end
        ISSUE: begin
          rst_evt_q <= 1'b0;
          up_evt_q  <= 1'b0;
          dn_evt_q  <= 1'b0;
          ho_cnt_q  <= '0;
          state_q   <= HOLDOFF;
          if (sel_q[B_RST])     level_q <= LEVEL_W'(LEVEL_DEFAULT);
          else if (sel_q[B_UP]) level_q <= level_q + LEVEL_W'(1);
          else                  level_q <= level_q - LEVEL_W'(1);
        end
        HOLDOFF: begin
          if (ho_cnt_q == HO_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            ho_cnt_q <= ho_cnt_q + HO_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          rst_evt_q <= 1'b0;
          up_evt_q  <= 1'b0;
          dn_evt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign speed_up_event    = up_evt_q;
  assign speed_down_event  = dn_evt_q;
  assign speed_reset_event = rst_evt_q;
  assign speed_level       = level_q;
  assign busy              = busy_q;

endmodule
